ahb3lite_gpio_timer_slv: RTL and testbench



---
 rtl/ahb3lite_gpio_timer_slv_pkg.sv | 45 ++++
 rtl/ahb3lite_gpio_timer_slv_if.sv | 24 ++
 rtl/ahb3lite_gpio_timer_slv_timer.sv | 72 +++++++
 rtl/ahb3lite_gpio_timer_slv.sv | 178 +++++++++++++++++
 tb/tb_ahb3lite_gpio_timer_slv.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb3lite_gpio_timer_slv_pkg.sv
// Shared constants, register map, FSM state type and address-decode helpers
// for the AHB3-Lite GPIO/timer responder.
package ahb3lite_gpio_timer_slv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // register index = haddr[4:2]
    localparam logic [2:0] REG_LED_OUT  = 3'd0;
    localparam logic [2:0] REG_LED_SET  = 3'd1;
    localparam logic [2:0] REG_LED_CLR  = 3'd2;
    localparam logic [2:0] REG_BTN_IN   = 3'd3;
    localparam logic [2:0] REG_TIM_CNT  = 3'd4;
    localparam logic [2:0] REG_TIM_CMP  = 3'd5;
    localparam logic [2:0] REG_TIM_CTRL = 3'd6;
    localparam logic [2:0] REG_TIM_STAT = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_AUTO   = 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    function automatic logic is_illegal(logic [6:0] addr_hi, logic [1:0] addr_lo,
                                        logic [2:0] size);
        return (|addr_hi) || (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && addr_lo[0]) ||
               ((size == HSIZE_WORD) && (|addr_lo));
    endfunction

    function automatic logic [31:0] lane_mask(logic [1:0] addr_lo, logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 32'h0000_00FF << {addr_lo, 3'b000};
            HSIZE_HALF: return addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_gpio_timer_slv_if.sv
// AHB3-Lite slave-port bundle between interconnect (master side) and the
// GPIO/timer responder (slave side).
interface ahb3lite_gpio_timer_slv_if;
    logic        hsel_i;
    logic [31:0] haddr_i;
    logic [31:0] hwdata_i;
    logic [31:0] hrdata_o;
    logic        hwrite_i;
    logic [2:0]  hsize_i;
    logic [1:0]  htrans_i;
    logic        hready_i;
    logic        hreadyout_o;
    logic        hresp_o;

    modport slave (
        input  hsel_i, haddr_i, hwdata_i, hwrite_i, hsize_i, htrans_i, hready_i,
        output hrdata_o, hreadyout_o, hresp_o
    );

    modport master (
        output hsel_i, haddr_i, hwdata_i, hwrite_i, hsize_i, htrans_i, hready_i,
        input  hrdata_o, hreadyout_o, hresp_o
    );
endinterface

// File: rtl/ahb3lite_gpio_timer_slv_timer.sv
// 32-bit prescaled up-counter with compare match, sticky flag and registered
// interrupt; all register writes arrive as strobes from the bus logic.
module cm0_timer_core
    import ahb3lite_gpio_timer_slv_pkg::*;
#(
    parameter int g_prescale = 1
) (
    input  logic        hclk_i,
    input  logic        rst_i,
    input  logic        i_cnt_we,
    input  logic [31:0] i_cnt_wdata,
    input  logic        i_cmp_we,
    input  logic [31:0] i_cmp_wdata,
    input  logic        i_ctrl_we,
    input  logic [2:0]  i_ctrl_wdata,
    input  logic        i_flag_clr,
    output logic [31:0] o_cnt,
    output logic [31:0] o_cmp,
    output logic [2:0]  o_ctrl,
    output logic        o_flag,
    output logic        o_irq
);
    localparam logic [15:0] LP_PRE_LAST = 16'(g_prescale - 1);

    logic [15:0] r_pre;
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [2:0]  r_ctrl;
    logic        r_flag;
    logic        r_irq;
    logic        w_tick;
    logic        w_match;

    assign w_tick  = r_ctrl[CTRL_EN] && (r_pre == LP_PRE_LAST);
    assign w_match = w_tick && (r_cnt == r_cmp);

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_cmp  <= '0;
            r_ctrl <= '0;
            r_flag <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            // a bus write to CNT wins over counting and restarts the prescaler
            if (i_cnt_we) begin
                r_cnt <= i_cnt_wdata;
                r_pre <= '0;
            end else if (r_ctrl[CTRL_EN]) begin
                r_pre <= w_tick ? '0 : r_pre + 16'd1;
                if (w_tick)
                    r_cnt <= (w_match && r_ctrl[CTRL_AUTO]) ? '0 : r_cnt + 32'd1;
            end
            if (i_cmp_we)
                r_cmp <= i_cmp_wdata;
            if (i_ctrl_we)
                r_ctrl <= i_ctrl_wdata;
            if (w_match)
                r_flag <= 1'b1;
            else if (i_flag_clr)
                r_flag <= 1'b0;
            r_irq <= r_flag && r_ctrl[CTRL_IRQ_EN];
        end
    end

    assign o_cnt  = r_cnt;
    assign o_cmp  = r_cmp;
    assign o_ctrl = r_ctrl;
    assign o_flag = r_flag;
    assign o_irq  = r_irq;
endmodule

// File: rtl/ahb3lite_gpio_timer_slv.sv
// AHB3-Lite responder: LED register with set/clear aliases, synchronised
// buttons, and a prescaled compare timer; optional wait states and ERROR response.
module ahb3lite_gpio_timer_slv
    import ahb3lite_gpio_timer_slv_pkg::*;
#(
    parameter int g_wait_states = 0,
    parameter int g_led_width   = 8,
    parameter int g_btn_width   = 1,
    parameter int g_prescale    = 1
) (
    input  logic                       hclk_i,
    input  logic                       rst_i,
    ahb3lite_gpio_timer_slv_if.slave   bus,
    input  logic [g_btn_width-1:0]     btn_i,
    output logic [g_led_width-1:0]     led_o,
    output logic                       irq_o
);
    localparam logic [1:0] LP_WAIT_INIT = 2'((g_wait_states > 0) ? g_wait_states - 1 : 0);

    state_t                 r_state;
    logic [1:0]             r_wait_cnt;
    logic                   r_hreadyout;
    logic                   r_hresp;
    logic                   r_pend;
    logic                   r_write;
    logic [2:0]             r_size;
    logic [4:0]             r_addr;
    logic [g_led_width-1:0] r_led;
    logic [g_btn_width-1:0] r_btn_meta;
    logic [g_btn_width-1:0] r_btn_sync;

    logic        w_accept;
    logic        w_illegal;
    logic        w_complete;
    logic        w_wr;
    logic        w_rd;
    logic [2:0]  w_reg;
    logic [31:0] w_mask;
    logic [31:0] w_wbits;
    logic [31:0] w_rdata;
    logic [31:0] w_tim_cnt;
    logic [31:0] w_tim_cmp;
    logic [2:0]  w_tim_ctrl;
    logic        w_tim_flag;
    logic        w_unused;

    assign w_accept   = bus.hsel_i && bus.hready_i && bus.htrans_i[1] && r_hreadyout;
    assign w_illegal  = is_illegal(bus.haddr_i[11:5], bus.haddr_i[1:0], bus.hsize_i);
    assign w_complete = r_pend && (r_state == S_IDLE);
    assign w_wr       = w_complete && r_write;
    assign w_rd       = w_complete && !r_write;
    assign w_reg      = r_addr[4:2];
    assign w_mask     = lane_mask(r_addr[1:0], r_size);
    assign w_wbits    = bus.hwdata_i & w_mask;
    assign w_unused   = &{1'b0, bus.haddr_i[31:12], bus.htrans_i[0]};

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR2: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= 1'b1;
                        end else if (g_wait_states > 0) begin
                            r_state     <= S_WAIT;
                            r_hreadyout <= 1'b0;
                            r_wait_cnt  <= LP_WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                end
            endcase
        end
    end

    // an overlapping address phase replaces the completing one
    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
        end else if (w_accept) begin
            r_pend  <= !w_illegal;
            r_write <= bus.hwrite_i;
            r_size  <= bus.hsize_i;
            r_addr  <= bus.haddr_i[4:0];
        end else if (w_complete) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge hclk_i) begin
        if (rst_i) begin
            r_led      <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            r_btn_meta <= btn_i;
            r_btn_sync <= r_btn_meta;
            if (w_wr) begin
                case (w_reg)
                    REG_LED_OUT: r_led <= (r_led & ~w_mask[g_led_width-1:0]) |
                                          w_wbits[g_led_width-1:0];
                    REG_LED_SET: r_led <= r_led | w_wbits[g_led_width-1:0];
                    REG_LED_CLR: r_led <= r_led & ~w_wbits[g_led_width-1:0];
                    default:     r_led <= r_led;
                endcase
            end
        end
    end

    cm0_timer_core #(
        .g_prescale (g_prescale)
    ) u_timer (
        .hclk_i       (hclk_i),
        .rst_i        (rst_i),
        .i_cnt_we     (w_wr && (w_reg == REG_TIM_CNT)),
        .i_cnt_wdata  ((w_tim_cnt & ~w_mask) | w_wbits),
        .i_cmp_we     (w_wr && (w_reg == REG_TIM_CMP)),
        .i_cmp_wdata  ((w_tim_cmp & ~w_mask) | w_wbits),
        .i_ctrl_we    (w_wr && (w_reg == REG_TIM_CTRL)),
        .i_ctrl_wdata ((w_tim_ctrl & ~w_mask[2:0]) | w_wbits[2:0]),
        .i_flag_clr   (w_wr && (w_reg == REG_TIM_STAT) && w_wbits[0]),
        .o_cnt        (w_tim_cnt),
        .o_cmp        (w_tim_cmp),
        .o_ctrl       (w_tim_ctrl),
        .o_flag       (w_tim_flag),
        .o_irq        (irq_o)
    );

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_reg)
                REG_LED_OUT:  w_rdata[g_led_width-1:0] = r_led;
                REG_BTN_IN:   w_rdata[g_btn_width-1:0] = r_btn_sync;
                REG_TIM_CNT:  w_rdata = w_tim_cnt;
                REG_TIM_CMP:  w_rdata = w_tim_cmp;
                REG_TIM_CTRL: w_rdata[2:0] = w_tim_ctrl;
                REG_TIM_STAT: w_rdata[0] = w_tim_flag;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.hrdata_o    = w_rdata;
    assign bus.hreadyout_o = r_hreadyout;
    assign bus.hresp_o     = r_hresp;
    assign led_o           = r_led;
endmodule

// File: tb/tb_ahb3lite_gpio_timer_slv.sv
// Directed bench: zero-wait instance for register/timer/error behaviour and a
// two-wait-state instance for stretched transfers and reset during a wait.
module tb_ahb3lite_gpio_timer_slv;
    import ahb3lite_gpio_timer_slv_pkg::*;

    logic       clk;
    logic       rst0;
    logic       rst2;
    logic       btn0;
    logic       btn2;
    logic [7:0] led0;
    logic [7:0] led2;
    logic       irq0;
    logic       irq2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_data;
    logic        rd_rdy;
    logic        rd_resp;

    ahb3lite_gpio_timer_slv_if bus0 ();
    ahb3lite_gpio_timer_slv_if bus2 ();

    assign bus0.hready_i = bus0.hreadyout_o;
    assign bus2.hready_i = bus2.hreadyout_o;

    ahb3lite_gpio_timer_slv #(
        .g_wait_states (0), .g_led_width (8), .g_btn_width (1), .g_prescale (1)
    ) u_dut0 (
        .hclk_i (clk), .rst_i (rst0), .bus (bus0),
        .btn_i (btn0), .led_o (led0), .irq_o (irq0)
    );

    ahb3lite_gpio_timer_slv #(
        .g_wait_states (2), .g_led_width (8), .g_btn_width (1), .g_prescale (1)
    ) u_dut2 (
        .hclk_i (clk), .rst_i (rst2), .bus (bus2),
        .btn_i (btn2), .led_o (led2), .irq_o (irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.hsel_i   = 1'b0;
        bus0.htrans_i = HTRANS_IDLE;
        bus0.hwrite_i = 1'b0;
    endtask

    task automatic addr0(input logic [31:0] a, input logic w, input logic [2:0] s);
        bus0.hsel_i   = 1'b1;
        bus0.haddr_i  = a;
        bus0.hwrite_i = w;
        bus0.hsize_i  = s;
        bus0.htrans_i = HTRANS_NONSEQ;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        addr0(a, 1'b1, s);
        step();
        idle0();
        bus0.hwdata_i = d;
        step();
    endtask

    task automatic rd0(input logic [31:0] a, input logic [2:0] s,
                       output logic [31:0] d, output logic rdy, output logic resp);
        addr0(a, 1'b0, s);
        step();
        idle0();
        d    = bus0.hrdata_o;
        rdy  = bus0.hreadyout_o;
        resp = bus0.hresp_o;
        step();
    endtask

    task automatic err0(input string tag, input logic [31:0] a, input logic [2:0] s);
        addr0(a, 1'b1, s);
        step();
        idle0();
        bus0.hwdata_i = 32'hFFFF_FFFF;
        chk({tag, "_err1_rdy"}, 32'(bus0.hreadyout_o), 32'd0);
        chk({tag, "_err1_resp"}, 32'(bus0.hresp_o), 32'd1);
        step();
        chk({tag, "_err2_rdy"}, 32'(bus0.hreadyout_o), 32'd1);
        chk({tag, "_err2_resp"}, 32'(bus0.hresp_o), 32'd1);
        step();
        chk({tag, "_after_resp"}, 32'(bus0.hresp_o), 32'd0);
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d);
        bus2.hsel_i   = 1'b1;
        bus2.haddr_i  = a;
        bus2.hwrite_i = 1'b1;
        bus2.hsize_i  = HSIZE_WORD;
        bus2.htrans_i = HTRANS_NONSEQ;
        step();
        bus2.hsel_i   = 1'b0;
        bus2.htrans_i = HTRANS_IDLE;
        bus2.hwdata_i = d;
        step();
        step();
        step();
    endtask

    initial begin
        rst0 = 1'b1;
        rst2 = 1'b1;
        btn0 = 1'b1;
        btn2 = 1'b1;
        idle0();
        bus0.haddr_i  = '0;
        bus0.hsize_i  = HSIZE_WORD;
        bus0.hwdata_i = '0;
        bus2.hsel_i   = 1'b0;
        bus2.htrans_i = HTRANS_IDLE;
        bus2.hwrite_i = 1'b0;
        bus2.haddr_i  = '0;
        bus2.hsize_i  = HSIZE_WORD;
        bus2.hwdata_i = '0;
        step();
        step();

        chk("rst_hreadyout", 32'(bus0.hreadyout_o), 32'd1);
        chk("rst_hresp", 32'(bus0.hresp_o), 32'd0);
        chk("rst_hrdata", bus0.hrdata_o, 32'd0);
        chk("rst_led", 32'(led0), 32'd0);
        chk("rst_irq", 32'(irq0), 32'd0);
        rst0 = 1'b0;
        rst2 = 1'b0;
        step();

        wr0(32'h00, 32'h0000_00A5, HSIZE_WORD);
        chk("led_write", 32'(led0), 32'hA5);
        rd0(32'h00, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("led_read_data", rd_data, 32'h0000_00A5);
        chk("led_read_resp", 32'(rd_resp), 32'd0);
        chk("led_read_rdy", 32'(rd_rdy), 32'd1);

        wr0(32'h00, 32'h0000_00A0, HSIZE_WORD);
        wr0(32'h04, 32'h0000_000F, HSIZE_WORD);
        chk("led_set", 32'(led0), 32'hAF);
        wr0(32'h08, 32'h0000_0005, HSIZE_WORD);
        chk("led_clr", 32'(led0), 32'hAA);
        rd0(32'h04, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("led_set_reads0", rd_data, 32'd0);

        wr0(32'h01, 32'h0000_FF00, HSIZE_BYTE);
        chk("led_byte_lane1", 32'(led0), 32'hAA);
        wr0(32'h00, 32'hFFFF_FF55, HSIZE_BYTE);
        chk("led_byte_lane0", 32'(led0), 32'h55);

        // pipelined write then read of the same register
        addr0(32'h00, 1'b1, HSIZE_WORD);
        step();
        bus0.hwdata_i = 32'h0000_003C;
        addr0(32'h00, 1'b0, HSIZE_WORD);
        step();
        idle0();
        chk("pipe_read_data", bus0.hrdata_o, 32'h0000_003C);
        chk("pipe_read_rdy", 32'(bus0.hreadyout_o), 32'd1);
        chk("pipe_led", 32'(led0), 32'h3C);
        step();

        rd0(32'h0C, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("btn_read", rd_data, 32'd1);

        err0("addr_oob", 32'h20, HSIZE_WORD);
        err0("half_misal", 32'h01, HSIZE_HALF);
        err0("size_big", 32'h00, 3'd3);
        chk("err_no_led_change", 32'(led0), 32'h3C);

        wr0(32'h14, 32'd3, HSIZE_WORD);
        wr0(32'h10, 32'd0, HSIZE_WORD);
        wr0(32'h18, 32'h7, HSIZE_WORD);
        chk("tim_cnt_start", u_dut0.u_timer.o_cnt, 32'd0);
        step();
        chk("tim_cnt_1", u_dut0.u_timer.o_cnt, 32'd1);
        step();
        chk("tim_cnt_2", u_dut0.u_timer.o_cnt, 32'd2);
        step();
        chk("tim_cnt_3", u_dut0.u_timer.o_cnt, 32'd3);
        chk("tim_irq_before", 32'(irq0), 32'd0);
        step();
        chk("tim_cnt_reload", u_dut0.u_timer.o_cnt, 32'd0);
        chk("tim_irq_lag", 32'(irq0), 32'd0);
        step();
        chk("tim_irq_set", 32'(irq0), 32'd1);
        wr0(32'h18, 32'h6, HSIZE_WORD);
        chk("tim_irq_hold", 32'(irq0), 32'd1);
        wr0(32'h1C, 32'h1, HSIZE_WORD);
        chk("tim_irq_w1c_lag", 32'(irq0), 32'd1);
        step();
        chk("tim_irq_cleared", 32'(irq0), 32'd0);
        rd0(32'h1C, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("tim_stat_read", rd_data, 32'd0);

        wr0(32'h10, 32'h1234_5678, HSIZE_WORD);
        wr0(32'h11, 32'h0000_AB00, HSIZE_BYTE);
        rd0(32'h10, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("tim_cnt_byte", rd_data, 32'h1234_AB78);
        rd0(32'h18, HSIZE_WORD, rd_data, rd_rdy, rd_resp);
        chk("tim_ctrl_read", rd_data, 32'h6);

        // two-wait-state instance
        bus2.hsel_i   = 1'b1;
        bus2.haddr_i  = 32'h0C;
        bus2.hwrite_i = 1'b0;
        bus2.hsize_i  = HSIZE_WORD;
        bus2.htrans_i = HTRANS_NONSEQ;
        step();
        bus2.hsel_i   = 1'b0;
        bus2.htrans_i = HTRANS_IDLE;
        chk("ws2_wait1", 32'(bus2.hreadyout_o), 32'd0);
        step();
        chk("ws2_wait2", 32'(bus2.hreadyout_o), 32'd0);
        step();
        chk("ws2_done_rdy", 32'(bus2.hreadyout_o), 32'd1);
        chk("ws2_done_data", bus2.hrdata_o, 32'd1);
        chk("ws2_done_resp", 32'(bus2.hresp_o), 32'd0);
        step();

        wr2(32'h00, 32'h0000_003C);
        chk("ws2_led", 32'(led2), 32'h3C);
        wr2(32'h10, 32'd5);
        chk("ws2_cnt", u_dut2.u_timer.o_cnt, 32'd5);

        bus2.hsel_i   = 1'b1;
        bus2.haddr_i  = 32'h00;
        bus2.hwrite_i = 1'b0;
        bus2.htrans_i = HTRANS_NONSEQ;
        step();
        bus2.hsel_i   = 1'b0;
        bus2.htrans_i = HTRANS_IDLE;
        chk("ws2_in_wait", 32'(bus2.hreadyout_o), 32'd0);
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        chk("ws2_rst_rdy", 32'(bus2.hreadyout_o), 32'd1);
        chk("ws2_rst_led", 32'(led2), 32'd0);
        chk("ws2_rst_cnt", u_dut2.u_timer.o_cnt, 32'd0);
        chk("ws2_rst_irq", 32'(irq2), 32'd0);
        step();
        chk("ws2_abandon_data", bus2.hrdata_o, 32'd0);
        chk("ws2_abandon_rdy", 32'(bus2.hreadyout_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
